itlb_ctrl: RTL and testbench
============================

ITLB_CTRL -- requirements
Module: itlb_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter ENTRIES, default 8, number of itlb_entry instances controlled (power of two, 2..32).
REQ-003 Parameter VPN_W, default 27, Sv39 virtual page number width.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 req_valid_i / req_ready_o  in/out  1/1  fetch translation request handshake.
REQ-007 req_vpn_i  in  VPN_W  VPN to translate.
REQ-008 resp_valid_o  out  1  one-cycle response pulse; no backpressure.
REQ-009 resp_hit_o / resp_fault_o  out  1/1  translation hit or PTW fault.
REQ-010 resp_pte_o  out  `MXLEN  translated PTE, zero when fault.
REQ-011 entry_rd_en_o / entry_wr_en_o  out  ENTRIES/ENTRIES  one-hot read/write enables to the entries.
REQ-012 entry_pte_wr_o  out  `MXLEN  refill PTE broadcast to all entries.
REQ-013 entry_pte_rd_i  in  ENTRIES x `MXLEN  entry read data, zero when not enabled.
REQ-014 ptw_req_valid_o / ptw_req_ready_i  out/in  1/1  page-walk request handshake; ptw_req_vpn_o  out  VPN_W.
REQ-015 ptw_resp_valid_i  in  1; ptw_resp_pte_i  in  `MXLEN; ptw_resp_err_i  in  1 (page fault/access fault).
REQ-016 flush_i  in  1  sfence.vma: invalidate all entries.

Function
REQ-017 Controller SHALL own per-entry valid bit and VPN tag; entries hold only PTE.
REQ-018 FSM states IDLE, LOOKUP, PTW_REQ, PTW_WAIT, REFILL.
REQ-019 IDLE: req_ready_o=1; on req_valid_i&req_ready_o latch VPN -> LOOKUP.
REQ-020 LOOKUP: compare latched VPN against all valid tags; on hit assert matching entry_rd_en_o, resp_valid_o=1, resp_hit_o=1, resp_pte_o=OR of entry_pte_rd_i -> IDLE (hit latency 1 cycle after acceptance).
REQ-021 LOOKUP miss -> PTW_REQ; ptw_req_valid_o held with stable VPN until ptw_req_ready_i -> PTW_WAIT.
REQ-022 PTW_WAIT: on ptw_resp_valid_i with err=0 -> REFILL; with err=1 -> resp_valid_o=1, resp_fault_o=1, no write -> IDLE.
REQ-023 REFILL: one-cycle entry_wr_en_o on victim, entry_pte_wr_o=PTW PTE, set valid and tag; same cycle resp_valid_o=1, resp_hit_o=0, resp_pte_o=PTW PTE -> IDLE.
REQ-024 Victim = lowest-index invalid entry; if all valid, round-robin pointer, incremented modulo ENTRIES after each refill that used it.
REQ-025 req_ready_o=0 in every state except IDLE.
REQ-026 Multiple tag matches impossible by construction; if present, lowest index wins.
REQ-027 flush_i clears all valid bits next edge; flush in IDLE takes priority over acceptance (req_ready_o=0 that cycle).
REQ-028 flush_i during LOOKUP: response suppressed, -> IDLE.
REQ-029 flush_i during PTW_REQ/PTW_WAIT: set cancel flag; PTW handshake completes normally, then no write, no response, -> IDLE.
REQ-030 flush_i coinciding with REFILL: write suppressed, response suppressed.

Reset
REQ-031 Reset: state IDLE, all valid=0, round-robin pointer=0, cancel flag=0.
REQ-032 During/after reset all outputs 0 except req_ready_o=1 from first cycle after rst_i deasserts.
REQ-033 Reset mid-walk drops transaction; late ptw_resp_valid_i in IDLE SHALL be ignored.

Configuration
REQ-034 ITLB_PERF_CNT_EN defined: add outputs perf_hit_o, perf_miss_o (32-bit, wrap at 2^32), incremented on LOOKUP hit/miss, cleared by reset only.
REQ-035 ITLB_PERF_CNT_EN undefined: counters and ports absent; behaviour otherwise identical.

Structure
REQ-036 mms_pkg SHALL hold itlb_state_e, ITLB_ENTRIES default, VPN width constant; pte_t reused from mms_pkg.
REQ-037 Sub-module itlb_victim_sel SHALL compute victim index from valid vector and round-robin pointer.

Verification
REQ-038 Reset, req VPN 0x123 -> miss, PTW req VPN 0x123, PTW PTE 0xABC -> write entry0, resp hit=0 pte 0xABC; repeat req -> resp hit=1 one cycle after accept.
REQ-039 Fill 8 distinct VPNs, 9th miss -> entry0 replaced (pointer 0->1), 10th miss -> entry1.
REQ-040 PTW resp err=1 -> resp_fault_o=1, resp_pte_o=0, no entry_wr_en_o pulse; same VPN next -> miss again.
REQ-041 flush_i asserted in PTW_WAIT -> PTW response consumed, no write, no resp_valid_o, then any prior VPN misses.
REQ-042 ptw_req_ready_i held 0 for 5 cycles -> ptw_req_valid_o and VPN stable, req_ready_o=0 throughout.
REQ-043 With ITLB_PERF_CNT_EN: 3 hits, 2 misses -> perf_hit_o=3, perf_miss_o=2.

Source files
------------

// File: rtl/mms_pkg.sv
// Shared memory-management types: PTE word, ITLB controller states and Sv39 sizing.
// `MXLEN falls back to 64 when the build does not supply it.
`ifndef MXLEN
`define MXLEN 64
`endif

package mms_pkg;

  localparam int ITLB_ENTRIES = 8;
  localparam int SV39_VPN_W   = 27;

  typedef logic [`MXLEN-1:0] pte_t;

  typedef enum logic [2:0] {
    ITLB_IDLE,
    ITLB_LOOKUP,
    ITLB_PTW_REQ,
    ITLB_PTW_WAIT,
    ITLB_REFILL
  } itlb_state_e;

endpackage

// File: rtl/itlb_victim_sel.sv
// Refill victim choice: lowest-index invalid entry, otherwise the round-robin pointer.
// use_rr_o tells the controller whether to advance the pointer after the refill.
module itlb_victim_sel #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3
) (
  input  logic [ENTRIES-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   victim_o,
  output logic               use_rr_o
);

  always_comb begin
    victim_o = rr_ptr_i;
    use_rr_o = 1'b1;
    // Scan downwards so the lowest invalid index is the last one written.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        victim_o = IDX_W'(i);
        use_rr_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/itlb_ctrl.sv
// Instruction TLB controller: owns valid bits and VPN tags, drives PTE-only entries and the PTW.
// Define ITLB_PERF_CNT_EN to add the perf_hit_o / perf_miss_o lookup counters.
module itlb_ctrl
  import mms_pkg::*;
#(
  parameter int ENTRIES = ITLB_ENTRIES,
  parameter int VPN_W   = SV39_VPN_W
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [VPN_W-1:0]              req_vpn_i,
  output logic                          resp_valid_o,
  output logic                          resp_hit_o,
  output logic                          resp_fault_o,
  output logic [`MXLEN-1:0]             resp_pte_o,
  output logic [ENTRIES-1:0]            entry_rd_en_o,
  output logic [ENTRIES-1:0]            entry_wr_en_o,
  output logic [`MXLEN-1:0]             entry_pte_wr_o,
  input  logic [ENTRIES-1:0][`MXLEN-1:0] entry_pte_rd_i,
  output logic                          ptw_req_valid_o,
  input  logic                          ptw_req_ready_i,
  output logic [VPN_W-1:0]              ptw_req_vpn_o,
  input  logic                          ptw_resp_valid_i,
  input  logic [`MXLEN-1:0]             ptw_resp_pte_i,
  input  logic                          ptw_resp_err_i,
`ifdef ITLB_PERF_CNT_EN
  output logic [31:0]                   perf_hit_o,
  output logic [31:0]                   perf_miss_o,
`endif
  input  logic                          flush_i
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [ENTRIES-1:0] ONE_HOT0 = ENTRIES'(1);

  itlb_state_e          state_q, state_d;
  logic [VPN_W-1:0]     vpn_q, vpn_d;
  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic                 cancel_q, cancel_d;
  pte_t                 pte_q, pte_d;
  logic [VPN_W-1:0]     tag_q [ENTRIES];

  logic [ENTRIES-1:0]   match;
  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx;
  logic [IDX_W-1:0]     victim_idx;
  logic                 victim_use_rr;
  pte_t                 pte_or;
  logic                 lookup_hit;
  logic                 lookup_miss;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    assign match[gi] = valid_q[gi] && (tag_q[gi] == vpn_q);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        tag_q[gi] <= '0;
      end else if (entry_wr_en_o[gi]) begin
        tag_q[gi] <= vpn_q;
      end
    end
  end

  // Duplicate tags cannot arise, but lowest index still wins if they do.
  always_comb begin
    hit_any = |match;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = IDX_W'(i);
    end
  end

  // Disabled entries return zero, so the OR yields the selected PTE.
  always_comb begin
    pte_or = '0;
    for (int i = 0; i < ENTRIES; i++) pte_or = pte_or | entry_pte_rd_i[i];
  end

  itlb_victim_sel #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_victim_sel (
    .valid_i  (valid_q),
    .rr_ptr_i (rr_q),
    .victim_o (victim_idx),
    .use_rr_o (victim_use_rr)
  );

  always_comb begin
    state_d         = state_q;
    vpn_d           = vpn_q;
    valid_d         = valid_q;
    rr_d            = rr_q;
    cancel_d        = cancel_q;
    pte_d           = pte_q;
    req_ready_o     = 1'b0;
    resp_valid_o    = 1'b0;
    resp_hit_o      = 1'b0;
    resp_fault_o    = 1'b0;
    resp_pte_o      = '0;
    entry_rd_en_o   = '0;
    entry_wr_en_o   = '0;
    entry_pte_wr_o  = '0;
    ptw_req_valid_o = 1'b0;
    ptw_req_vpn_o   = '0;
    lookup_hit      = 1'b0;
    lookup_miss     = 1'b0;

    // Outputs stay quiet while reset is held.
    if (!rst_i) begin
      if (flush_i) valid_d = '0;

      unique case (state_q)
        ITLB_IDLE: begin
          req_ready_o = !flush_i;
          if (req_valid_i && !flush_i) begin
            vpn_d   = req_vpn_i;
            state_d = ITLB_LOOKUP;
          end
        end

        ITLB_LOOKUP: begin
          if (flush_i) begin
            state_d = ITLB_IDLE;
          end else if (hit_any) begin
            entry_rd_en_o = ONE_HOT0 << hit_idx;
            resp_valid_o  = 1'b1;
            resp_hit_o    = 1'b1;
            resp_pte_o    = pte_or;
            lookup_hit    = 1'b1;
            state_d       = ITLB_IDLE;
          end else begin
            lookup_miss = 1'b1;
            state_d     = ITLB_PTW_REQ;
          end
        end

        ITLB_PTW_REQ: begin
          ptw_req_valid_o = 1'b1;
          ptw_req_vpn_o   = vpn_q;
          if (flush_i) cancel_d = 1'b1;
          if (ptw_req_ready_i) state_d = ITLB_PTW_WAIT;
        end

        ITLB_PTW_WAIT: begin
          if (flush_i) cancel_d = 1'b1;
          if (ptw_resp_valid_i) begin
            if (cancel_q || flush_i) begin
              // Walk was for a now-stale context: swallow it silently.
              cancel_d = 1'b0;
              state_d  = ITLB_IDLE;
            end else if (ptw_resp_err_i) begin
              resp_valid_o = 1'b1;
              resp_fault_o = 1'b1;
              state_d      = ITLB_IDLE;
            end else begin
              pte_d   = ptw_resp_pte_i;
              state_d = ITLB_REFILL;
            end
          end
        end

        ITLB_REFILL: begin
          if (!flush_i) begin
            entry_wr_en_o       = ONE_HOT0 << victim_idx;
            entry_pte_wr_o      = pte_q;
            valid_d[victim_idx] = 1'b1;
            resp_valid_o        = 1'b1;
            resp_pte_o          = pte_q;
            if (victim_use_rr) rr_d = rr_q + 1'b1;
          end
          state_d = ITLB_IDLE;
        end

        default: state_d = ITLB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ITLB_IDLE;
      vpn_q    <= '0;
      valid_q  <= '0;
      rr_q     <= '0;
      cancel_q <= 1'b0;
      pte_q    <= '0;
    end else begin
      state_q  <= state_d;
      vpn_q    <= vpn_d;
      valid_q  <= valid_d;
      rr_q     <= rr_d;
      cancel_q <= cancel_d;
      pte_q    <= pte_d;
    end
  end

`ifdef ITLB_PERF_CNT_EN
  logic [31:0] perf_hit_q, perf_miss_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      if (lookup_hit)  perf_hit_q  <= perf_hit_q + 32'd1;
      if (lookup_miss) perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
`else
  logic unused_perf;
  assign unused_perf = lookup_hit ^ lookup_miss;
`endif

endmodule

// File: tb/tb_itlb_ctrl.sv
// Self-checking bench for itlb_ctrl: behavioural entries and PTW, reference TLB model feeding a scoreboard.
// Perf-counter checks are compiled in when ITLB_PERF_CNT_EN is defined.
`ifndef MXLEN
`define MXLEN 64
`endif

module tb_itlb_ctrl;

  localparam int ENTRIES = 8;
  localparam int VPN_W   = 27;
  localparam int XLEN    = `MXLEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                          req_valid = 1'b0;
  logic                          req_ready;
  logic [VPN_W-1:0]              req_vpn = '0;
  logic                          resp_valid, resp_hit, resp_fault;
  logic [XLEN-1:0]               resp_pte;
  logic [ENTRIES-1:0]            rd_en, wr_en;
  logic [XLEN-1:0]               pte_wr;
  logic [ENTRIES-1:0][XLEN-1:0]  pte_rd;
  logic                          ptw_req_valid;
  logic                          ptw_req_ready = 1'b0;
  logic [VPN_W-1:0]              ptw_req_vpn;
  logic                          ptw_resp_valid = 1'b0;
  logic [XLEN-1:0]               ptw_resp_pte = '0;
  logic                          ptw_resp_err = 1'b0;
  logic                          flush = 1'b0;
`ifdef ITLB_PERF_CNT_EN
  logic [31:0]                   perf_hit, perf_miss;
`endif

  itlb_ctrl #(.ENTRIES(ENTRIES), .VPN_W(VPN_W)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_vpn_i        (req_vpn),
    .resp_valid_o     (resp_valid),
    .resp_hit_o       (resp_hit),
    .resp_fault_o     (resp_fault),
    .resp_pte_o       (resp_pte),
    .entry_rd_en_o    (rd_en),
    .entry_wr_en_o    (wr_en),
    .entry_pte_wr_o   (pte_wr),
    .entry_pte_rd_i   (pte_rd),
    .ptw_req_valid_o  (ptw_req_valid),
    .ptw_req_ready_i  (ptw_req_ready),
    .ptw_req_vpn_o    (ptw_req_vpn),
    .ptw_resp_valid_i (ptw_resp_valid),
    .ptw_resp_pte_i   (ptw_resp_pte),
    .ptw_resp_err_i   (ptw_resp_err),
`ifdef ITLB_PERF_CNT_EN
    .perf_hit_o       (perf_hit),
    .perf_miss_o      (perf_miss),
`endif
    .flush_i          (flush)
  );

  // Behavioural PTE-only entries: write on enable, zero read data unless enabled.
  logic [XLEN-1:0] ent_mem [ENTRIES];
  initial for (int i = 0; i < ENTRIES; i++) ent_mem[i] = '0;
  always @(posedge clk) for (int i = 0; i < ENTRIES; i++) if (wr_en[i]) ent_mem[i] <= pte_wr;
  always_comb begin
    pte_rd = '0;
    for (int i = 0; i < ENTRIES; i++) if (rd_en[i]) pte_rd[i] = ent_mem[i];
  end

  typedef struct {
    bit              has_resp;
    bit              hit;
    bit              fault;
    logic [XLEN-1:0] pte;
    int              wr_idx;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference TLB state
  bit               m_valid [ENTRIES];
  logic [VPN_W-1:0] m_tag   [ENTRIES];
  logic [XLEN-1:0]  m_pte   [ENTRIES];
  int               m_rr;

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_rr = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One translation: predict, push expectation, drive, act as PTW, pop and compare.
  task automatic do_req(input logic [VPN_W-1:0] vpn, input logic [XLEN-1:0] pte,
                        input bit err, input int stall, input bit flush_walk);
    exp_t e, x;
    int hi, v, age, waitc, resp_cnt, resp_cyc, wr_idx, wr_cnt;
    bit walk, done, hs, consumed;
    logic g_hit, g_fault;
    logic [XLEN-1:0] g_pte, g_wr_pte;

    hi = -1;
    for (int i = 0; i < ENTRIES; i++) if (hi < 0 && m_valid[i] && m_tag[i] == vpn) hi = i;
    e.wr_idx = -1; e.hit = 0; e.fault = 0; e.pte = '0; e.has_resp = 1;
    if (hi >= 0) begin
      e.hit = 1; e.pte = m_pte[hi];
    end else if (flush_walk) begin
      e.has_resp = 0;
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else if (err) begin
      e.fault = 1;
    end else begin
      v = -1;
      for (int i = 0; i < ENTRIES; i++) if (v < 0 && !m_valid[i]) v = i;
      if (v < 0) begin v = m_rr; m_rr = (m_rr + 1) % ENTRIES; end
      m_valid[v] = 1'b1; m_tag[v] = vpn; m_pte[v] = pte;
      e.pte = pte; e.wr_idx = v;
    end
    sb.push_back(e);

    req_valid = 1'b1; req_vpn = vpn;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL accept_ready vpn=%h got=%b want=1", vpn, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;

    walk = 0; age = 0; waitc = 0; done = 0;
    resp_cnt = 0; resp_cyc = -1; wr_idx = -1; wr_cnt = 0;
    g_hit = 0; g_fault = 0; g_pte = '0; g_wr_pte = '0;
    for (int c = 0; c < 100 && !done; c++) begin
      ptw_req_ready  = (waitc >= stall);
      ptw_resp_valid = walk && (age >= 1);
      ptw_resp_pte   = pte;
      ptw_resp_err   = err;
      flush          = flush_walk && walk && (age == 0);
      @(negedge clk);
      if (resp_valid) begin
        resp_cnt++; resp_cyc = c;
        g_hit = resp_hit; g_fault = resp_fault; g_pte = resp_pte;
      end
      if (|wr_en) begin
        wr_cnt++; g_wr_pte = pte_wr;
        for (int i = 0; i < ENTRIES; i++) if (wr_en[i]) wr_idx = i;
      end
      if (ptw_req_valid) begin
        checks++;
        if (ptw_req_vpn !== vpn) begin
          failures++; $display("FAIL ptw_vpn cyc=%0d got=%h want=%h", c, ptw_req_vpn, vpn);
        end
        if (!ptw_req_ready) begin
          checks++;
          if (req_ready !== 1'b0) begin
            failures++; $display("FAIL stall_ready cyc=%0d got=%b want=0", c, req_ready);
          end
        end
      end
      hs = ptw_req_valid && ptw_req_ready;
      consumed = ptw_resp_valid;
      if (req_ready === 1'b1) done = 1;
      @(posedge clk); #1;
      if (consumed) walk = 0;
      if (hs) begin walk = 1; age = 0; end
      else if (walk) age++;
      if (ptw_req_valid && !ptw_req_ready) waitc++;
    end
    ptw_req_ready = 0; ptw_resp_valid = 0; ptw_resp_err = 0; flush = 0;

    x = sb.pop_front();
    checks++;
    if (!done) begin
      failures++; $display("FAIL timeout vpn=%h got=busy want=idle", vpn);
    end
    checks++;
    if (resp_cnt != (x.has_resp ? 1 : 0)) begin
      failures++; $display("FAIL resp_count vpn=%h got=%0d want=%0d", vpn, resp_cnt, x.has_resp ? 1 : 0);
    end
    if (x.has_resp && resp_cnt > 0) begin
      checks++;
      if (g_hit !== x.hit || g_fault !== x.fault || g_pte !== x.pte) begin
        failures++;
        $display("FAIL resp_fields vpn=%h got hit=%b fault=%b pte=%h want hit=%b fault=%b pte=%h",
                 vpn, g_hit, g_fault, g_pte, x.hit, x.fault, x.pte);
      end
      if (x.hit) begin
        checks++;
        if (resp_cyc != 0) begin
          failures++; $display("FAIL hit_latency vpn=%h got=%0d want=0", vpn, resp_cyc);
        end
      end
    end
    checks++;
    if (wr_idx != x.wr_idx || wr_cnt != (x.wr_idx >= 0 ? 1 : 0)) begin
      failures++; $display("FAIL write_entry vpn=%h got idx=%0d n=%0d want idx=%0d", vpn, wr_idx, wr_cnt, x.wr_idx);
    end
    if (x.wr_idx >= 0) begin
      checks++;
      if (g_wr_pte !== x.pte) begin
        failures++; $display("FAIL write_pte vpn=%h got=%h want=%h", vpn, g_wr_pte, x.pte);
      end
    end
    $display("txn vpn=%h resp=%0d hit=%b fault=%b pte=%h wr=%0d", vpn, resp_cnt, g_hit, g_fault, g_pte, wr_idx);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; ptw_resp_valid = 1'b1; ptw_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, ptw_req_valid, |rd_en, |wr_en, |resp_pte} !== 6'b0) begin
      failures++; $display("FAIL reset_outputs got=%b want=000000",
                           {req_ready, resp_valid, ptw_req_valid, |rd_en, |wr_en, |resp_pte});
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; ptw_resp_valid = 1'b0; ptw_req_ready = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, ptw_req_valid, |wr_en} !== 4'b1000) begin
      failures++; $display("FAIL post_reset got=%b want=1000", {req_ready, resp_valid, ptw_req_valid, |wr_en});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_miss_refill_hit();
    do_req(27'h123, 64'hABC, 0, 0, 0);
    do_req(27'h123, 64'hABC, 0, 0, 0);
  endtask

  task automatic test_replacement();
    reset_dut();
    for (int i = 0; i < ENTRIES; i++) do_req(27'h100 + 27'(i), 64'h1000 + 64'(i), 0, 0, 0);
    do_req(27'h200, 64'h2000, 0, 0, 0);
    do_req(27'h100, 64'h3000, 0, 0, 0);
    do_req(27'h102, 64'h0, 0, 0, 0);
  endtask

  task automatic test_fault();
    do_req(27'h300, 64'hDEAD, 1, 0, 0);
    do_req(27'h300, 64'h3300, 0, 0, 0);
  endtask

  task automatic test_flush_walk();
    do_req(27'h400, 64'h4400, 0, 0, 1);
    do_req(27'h200, 64'h5200, 0, 0, 0);
    do_req(27'h300, 64'h5300, 0, 0, 0);
  endtask

  task automatic test_ptw_stall();
    do_req(27'h500, 64'h5500, 0, 5, 0);
  endtask

  task automatic test_flush_idle();
    req_valid = 1'b1; req_vpn = 27'h200; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL flush_idle_ready got=%b want=0", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    model_reset_valid_only();
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      failures++; $display("FAIL flush_idle_state got=%b want=10", {req_ready, resp_valid});
    end
    @(posedge clk); #1;
    do_req(27'h200, 64'h6200, 0, 0, 0);
  endtask

  task automatic model_reset_valid_only();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [VPN_W-1:0] vpns [6] = '{27'h700, 27'h701, 27'h700, 27'h701, 27'h200, 27'h702};
    for (int i = 0; i < 6; i++) do_req(vpns[i], 64'h7000 + 64'(i), 0, 0, 0);
  endtask

  task automatic test_reset_mid_walk();
    ptw_req_ready = 1'b1;
    req_valid = 1'b1; req_vpn = 27'h777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 ptw_req_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    ptw_resp_valid = 1'b1; ptw_resp_pte = 64'h7777;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, |wr_en} !== 3'b100) begin
      failures++; $display("FAIL late_ptw_resp got=%b want=100", {req_ready, resp_valid, |wr_en});
    end
    @(posedge clk); #1;
    ptw_resp_valid = 1'b0;
    do_req(27'h777, 64'h8777, 0, 0, 0);
  endtask

`ifdef ITLB_PERF_CNT_EN
  task automatic test_perf();
    reset_dut();
    do_req(27'h10, 64'h10, 0, 0, 0);
    do_req(27'h10, 64'h10, 0, 0, 0);
    do_req(27'h11, 64'h11, 0, 0, 0);
    do_req(27'h11, 64'h11, 0, 0, 0);
    do_req(27'h10, 64'h10, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (perf_hit !== 32'd3 || perf_miss !== 32'd2) begin
      failures++; $display("FAIL perf_counts got hit=%0d miss=%0d want hit=3 miss=2", perf_hit, perf_miss);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_miss_refill_hit();
    test_replacement();
    test_fault();
    test_flush_walk();
    test_ptw_stall();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid_walk();
`ifdef ITLB_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
